// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: decodes the CPU data port into NDEV device slots, merges wait requests,
// signals error completions and keeps the last error address. Macro DATA_BUS_TIMEOUT_EN enables the ACCESS timeout.
module data_bus_ctrl #(
    parameter int             DW       = 16,
    parameter int             AW       = 16,
    parameter int             DEV_BITS = 4,
    parameter int             NDEV     = 2,
    parameter int             TIMEOUT  = 15,
    parameter logic [DW-1:0]  ERR_DATA = 16'hDEAD
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [AW-1:0]        DataAddr,
    input  logic [DW-1:0]        BusIn,
    output logic [DW-1:0]        BusOut,
    output logic                 Waitreq,
    output logic                 BusErr,
    output logic [AW-1:0]        LastErrAddr,
    output logic [NDEV-1:0]      DevRead,
    output logic [NDEV-1:0]      DevWrite,
    output logic [AW-DEV_BITS-1:0] DevAddr,
    output logic [DW-1:0]        DevWdata,
    input  logic [NDEV*DW-1:0]   DevRdata,
    input  logic [NDEV-1:0]      DevWait
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    if (NDEV < 1 || NDEV > 2**DEV_BITS || TIMEOUT < 1) begin : g_param_check
        $error("data_bus_ctrl: NDEV or TIMEOUT out of range");
    end

    state_t              state_r, state_s;
    logic [DEV_BITS-1:0] sel_r, sel_s, dev_idx_s;
    logic                is_wr_r, is_wr_s;
    logic [AW-1:0]       last_err_r;
    logic [NDEV-1:0]     dev_hit_s, sel_hit_s, dev_read_s, dev_write_s;
    logic [DW-1:0]       hit_rdata_s, sel_rdata_s, bus_out_s;
    logic                hit_wait_s, sel_wait_s, req_s, err_req_s, mapped_s;
    logic                wait_s, bus_err_s, err_cap_s, timeout_s;

    assign dev_idx_s = DataAddr[AW-1:AW-DEV_BITS];
    assign mapped_s  = (32'(dev_idx_s) < 32'(NDEV));
    assign req_s     = ReadData | WriteData;
    assign err_req_s = req_s & (~mapped_s | (ReadData & WriteData));

    // One-hot slot match for the current address and for the latched selection, with data/wait muxes
    always_comb begin
        dev_hit_s   = '0;
        sel_hit_s   = '0;
        hit_rdata_s = '0;
        sel_rdata_s = '0;
        for (int i = 0; i < NDEV; i++) begin
            dev_hit_s[i] = (dev_idx_s == DEV_BITS'(i));
            sel_hit_s[i] = (sel_r == DEV_BITS'(i));
            hit_rdata_s  = hit_rdata_s | (DevRdata[i*DW +: DW] & {DW{dev_hit_s[i]}});
            sel_rdata_s  = sel_rdata_s | (DevRdata[i*DW +: DW] & {DW{sel_hit_s[i]}});
        end
        hit_wait_s = |(DevWait & dev_hit_s);
        sel_wait_s = |(DevWait & sel_hit_s);
    end

`ifdef DATA_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_r, timer_s;

    assign timeout_s = (timer_r == TW'(TIMEOUT));

    // Wait-state counter: 1 on entry to ACCESS, then counts up and saturates at TIMEOUT
    always_comb begin
        timer_s = '0;
        if (state_s == ACCESS && state_r == IDLE) begin
            timer_s = TW'(1);
        end else if (state_s == ACCESS) begin
            timer_s = timeout_s ? timer_r : timer_r + TW'(1);
        end else begin
            timer_s = '0;
        end
    end

    // Timer register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Transaction FSM: next state, slot strobes and CPU-side responses
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        is_wr_s     = is_wr_r;
        dev_read_s  = '0;
        dev_write_s = '0;
        wait_s      = 1'b0;
        bus_out_s   = '0;
        bus_err_s   = 1'b0;
        err_cap_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (err_req_s) begin
                    bus_out_s = ERR_DATA;
                    bus_err_s = 1'b1;
                    err_cap_s = 1'b1;
                end else if (req_s) begin
                    dev_read_s  = ReadData  ? dev_hit_s : '0;
                    dev_write_s = WriteData ? dev_hit_s : '0;
                    if (hit_wait_s) begin
                        wait_s  = 1'b1;
                        sel_s   = dev_idx_s;
                        is_wr_s = WriteData;
                        state_s = ACCESS;
                    end else begin
                        bus_out_s = hit_rdata_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (!req_s) begin
                    state_s = IDLE;
                end else if (!sel_wait_s) begin
                    dev_read_s  = is_wr_r ? '0 : sel_hit_s;
                    dev_write_s = is_wr_r ? sel_hit_s : '0;
                    bus_out_s   = sel_rdata_s;
                    state_s     = IDLE;
                end else if (timeout_s) begin
                    bus_out_s = ERR_DATA;
                    bus_err_s = 1'b1;
                    err_cap_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    dev_read_s  = is_wr_r ? '0 : sel_hit_s;
                    dev_write_s = is_wr_r ? sel_hit_s : '0;
                    wait_s      = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, selected slot, access type and last error address
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r    <= IDLE;
            sel_r      <= '0;
            is_wr_r    <= 1'b0;
            last_err_r <= '0;
        end else begin
            state_r    <= state_s;
            sel_r      <= sel_s;
            is_wr_r    <= is_wr_s;
            last_err_r <= err_cap_s ? DataAddr : last_err_r;
        end
    end

    // Response paths are combinational so zero-wait slots complete in one cycle; reset forces them quiet
    assign DevRead     = Resetn ? dev_read_s  : '0;
    assign DevWrite    = Resetn ? dev_write_s : '0;
    assign Waitreq     = Resetn ? wait_s      : 1'b0;
    assign BusErr      = Resetn ? bus_err_s   : 1'b0;
    assign BusOut      = Resetn ? bus_out_s   : '0;
    assign DevAddr     = DataAddr[AW-DEV_BITS-1:0];
    assign DevWdata    = BusIn;
    assign LastErrAddr = last_err_r;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed self-checking bench for data_bus_ctrl (default parameters, NDEV=2).
module tb_data_bus_ctrl;
    logic        Clock, Resetn, ReadData, WriteData;
    logic [15:0] DataAddr, BusIn, BusOut, LastErrAddr, DevWdata;
    logic        Waitreq, BusErr;
    logic [1:0]  DevRead, DevWrite, DevWait;
    logic [11:0] DevAddr;
    logic [31:0] DevRdata;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int wcnt;
    logic err_seen;

`ifdef DATA_BUS_TIMEOUT_EN
    localparam int LIM = 40;
`else
    localparam int LIM = 120;
`endif

    data_bus_ctrl dut (
        .Clock(Clock), .Resetn(Resetn), .ReadData(ReadData), .WriteData(WriteData),
        .DataAddr(DataAddr), .BusIn(BusIn), .BusOut(BusOut), .Waitreq(Waitreq),
        .BusErr(BusErr), .LastErrAddr(LastErrAddr), .DevRead(DevRead), .DevWrite(DevWrite),
        .DevAddr(DevAddr), .DevWdata(DevWdata), .DevRdata(DevRdata), .DevWait(DevWait)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn = 1'b0; ReadData = 1'b1; WriteData = 1'b0; DataAddr = 16'h0010;
        BusIn = 16'h0000; DevWait = 2'b00; DevRdata = {16'h5678, 16'h1234};
        #12;
        check_val("rst_devread", DevRead, 2'b00);
        check_val("rst_busout", BusOut, 16'h0000);
        check_val("rst_lasterr", LastErrAddr, 16'h0000);
        check_val("rst_wait", Waitreq, 1'b0);

        // zero-wait read, slot 0
        @(negedge Clock); Resetn = 1'b1; #1;
        check_val("rd0_devread", DevRead, 2'b01);
        check_val("rd0_wait", Waitreq, 1'b0);
        check_val("rd0_busout", BusOut, 16'h1234);
        check_val("rd0_buserr", BusErr, 1'b0);
        check_val("rd0_devaddr", DevAddr, 12'h010);

        // back-to-back zero-wait read, slot 1
        @(negedge Clock); DataAddr = 16'h1002; #1;
        check_val("rd1_devread", DevRead, 2'b10);
        check_val("rd1_busout", BusOut, 16'h5678);

        // write to slot 1 with three wait cycles; address wobble in cycle 1 must not move sel
        ReadData = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            WriteData = 1'b1; BusIn = 16'hBEEF;
            DataAddr = (k == 1) ? 16'h0004 : 16'h1004;
            DevWait  = (k < 3) ? 2'b10 : 2'b00;
            #1;
            check_val($sformatf("wr_devwrite%0d", k), DevWrite, 2'b10);
            check_val($sformatf("wr_wait%0d", k), Waitreq, (k < 3) ? 1'b1 : 1'b0);
            check_val($sformatf("wr_devaddr%0d", k), DevAddr, 12'h004);
            check_val($sformatf("wr_wdata%0d", k), DevWdata, 16'hBEEF);
        end
        @(negedge Clock); WriteData = 1'b0; #1;
        check_val("wr_done_devwrite", DevWrite, 2'b00);
        check_val("wr_done_wait", Waitreq, 1'b0);

        // unmapped read
        @(negedge Clock); ReadData = 1'b1; DataAddr = 16'h5000; #1;
        check_val("unm_devread", DevRead, 2'b00);
        check_val("unm_wait", Waitreq, 1'b0);
        check_val("unm_busout", BusOut, 16'hDEAD);
        check_val("unm_buserr", BusErr, 1'b1);
        @(negedge Clock); ReadData = 1'b0; #1;
        check_val("unm_buserr_drop", BusErr, 1'b0);
        check_val("unm_lasterr", LastErrAddr, 16'h5000);

        // both strobes high
        @(negedge Clock); ReadData = 1'b1; WriteData = 1'b1; DataAddr = 16'h0000; #1;
        check_val("both_devread", DevRead, 2'b00);
        check_val("both_devwrite", DevWrite, 2'b00);
        check_val("both_buserr", BusErr, 1'b1);
        check_val("both_busout", BusOut, 16'hDEAD);
        @(negedge Clock); ReadData = 1'b0; WriteData = 1'b0; #1;
        check_val("both_lasterr", LastErrAddr, 16'h0000);

        // slot 1 wait stuck high
        wcnt = 0; err_seen = 1'b0;
        @(negedge Clock); ReadData = 1'b1; DataAddr = 16'h1008; DevWait = 2'b10; #1;
        while (Waitreq && wcnt < LIM) begin
            if (BusErr) err_seen = 1'b1;
            wcnt++;
            @(negedge Clock); #1;
        end
        check_val("stuck_err_seen", err_seen, 1'b0);
`ifdef DATA_BUS_TIMEOUT_EN
        check_val("stuck_wait_cycles", wcnt, 15);
        check_val("abort_buserr", BusErr, 1'b1);
        check_val("abort_busout", BusOut, 16'hDEAD);
        check_val("abort_devread", DevRead, 2'b00);
        @(negedge Clock); ReadData = 1'b0; DevWait = 2'b00; #1;
        check_val("abort_lasterr", LastErrAddr, 16'h1008);
`else
        check_val("stuck_wait_cycles", wcnt, 120);
        check_val("stuck_devread", DevRead, 2'b10);
        ReadData = 1'b0; #1;
        check_val("drop_devread", DevRead, 2'b00);
        check_val("drop_wait", Waitreq, 1'b0);
        @(negedge Clock); DevWait = 2'b00; #1;
        check_val("drop_buserr", BusErr, 1'b0);
        check_val("drop_lasterr", LastErrAddr, 16'h0000);
`endif

        // fresh error so the reset clear of LastErrAddr is visible
        @(negedge Clock); ReadData = 1'b1; DataAddr = 16'hF000; #1;
        check_val("unmf_buserr", BusErr, 1'b1);
        @(negedge Clock); ReadData = 1'b0; #1;
        check_val("unmf_lasterr", LastErrAddr, 16'hF000);

        // reset in the middle of an ACCESS on slot 1
        @(negedge Clock); WriteData = 1'b1; DataAddr = 16'h1010; DevWait = 2'b10; #1;
        check_val("mid_wait_idle", Waitreq, 1'b1);
        @(negedge Clock); #1;
        check_val("mid_devwrite", DevWrite, 2'b10);
        Resetn = 1'b0; #1;
        check_val("mid_rst_devwrite", DevWrite, 2'b00);
        check_val("mid_rst_wait", Waitreq, 1'b0);
        check_val("mid_rst_lasterr", LastErrAddr, 16'h0000);
        @(negedge Clock);
        Resetn = 1'b1; WriteData = 1'b0; ReadData = 1'b1; DataAddr = 16'h0010; DevWait = 2'b00; #1;
        check_val("post_rst_devread", DevRead, 2'b01);
        check_val("post_rst_devwrite", DevWrite, 2'b00);
        check_val("post_rst_busout", BusOut, 16'h1234);
        check_val("post_rst_wait", Waitreq, 1'b0);
        @(negedge Clock); ReadData = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
